irda_sir_frame_encoder: RTL and testbench

IRDA_SIR_FRAME_ENCODER -- requirements
Module: irda_sir_frame_encoder

---
 rtl/irda_sir_frame_encoder.sv | 145 ++++++++++++++
 tb/tb_irda_sir_frame_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/irda_sir_frame_encoder.sv
// irda_sir_frame_encoder: UART-style frame to IrDA SIR return-to-zero pulses (3/16 bit or short pulse).
// Define IRDA_SIR_ENC_PARITY_EN to add a parity bit (input parity_odd) between data and stop.
module irda_sir_frame_encoder #(
    parameter int OVS        = 16,
    parameter int DATA_BITS  = 8,
    parameter int SHORT_CLKS = 4
) (
    input  logic                 clk,
    input  logic                 wb_rst_n,
    input  logic                 fast_mode,
    input  logic                 baud_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 pulse_mode,
`ifdef IRDA_SIR_ENC_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 sir_enc_o,
    output logic                 busy
);
    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);
    localparam int W  = (3 * OVS) / 16 < 1 ? 1 : (3 * OVS) / 16;
    localparam logic [TW-1:0] T_HALF = TW'(OVS / 2);
    localparam logic [TW-1:0] T_END  = TW'(OVS / 2 + W - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [7:0]    P_LOAD = 8'(SHORT_CLKS - 1);

`ifdef IRDA_SIR_ENC_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 mode;
    logic [7:0]           pc;
    logic                 last, accept, tick_en, zero_bit, sir_nxt;
    logic [7:0]           pc_nxt;

    assign last     = baud_en && tick == T_LAST;
    assign tx_ready = wb_rst_n && !fast_mode && (state == IDLE || (state == STOP && last));
    assign accept   = tx_valid && tx_ready;
    assign tick_en  = baud_en && state != IDLE;

    always_comb begin
        zero_bit = state == START || (state == DATA && !shreg[0]);
`ifdef IRDA_SIR_ENC_PARITY_EN
        zero_bit = zero_bit || (state == PARITY && !par);
`endif
    end

    // Short pulses count clk cycles on their own; any pulse is cut at the bit boundary.
    always_comb begin
        sir_nxt = sir_enc_o;
        pc_nxt  = pc;
        if (mode) begin
            if (sir_enc_o) begin
                sir_nxt = pc != 8'd0;
                pc_nxt  = pc != 8'd0 ? pc - 8'd1 : pc;
            end
            if (tick_en && zero_bit && tick == T_HALF) begin
                sir_nxt = 1'b1;
                pc_nxt  = P_LOAD;
            end
        end else if (tick_en) begin
            sir_nxt = zero_bit && tick >= T_HALF && tick <= T_END;
        end
        if (tick_en && tick == T_LAST)
            sir_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= IDLE;
            tick      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            mode      <= 1'b0;
            pc        <= 8'd0;
            sir_enc_o <= 1'b0;
            busy      <= 1'b0;
`ifdef IRDA_SIR_ENC_PARITY_EN
            par       <= 1'b0;
`endif
        end else if (fast_mode) begin
            state     <= IDLE;
            tick      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            mode      <= 1'b0;
            pc        <= 8'd0;
            sir_enc_o <= 1'b0;
            busy      <= 1'b0;
`ifdef IRDA_SIR_ENC_PARITY_EN
            par       <= 1'b0;
`endif
        end else if (accept) begin
            state     <= START;
            tick      <= '0;
            bcnt      <= '0;
            shreg     <= tx_data;
            mode      <= pulse_mode;
            pc        <= 8'd0;
            sir_enc_o <= 1'b0;
            busy      <= 1'b1;
`ifdef IRDA_SIR_ENC_PARITY_EN
            par       <= ^tx_data ^ parity_odd;
`endif
        end else begin
            sir_enc_o <= sir_nxt;
            pc        <= pc_nxt;
            if (tick_en) begin
                tick <= last ? '0 : tick + 1'b1;
                if (last) begin
                    unique case (state)
                        START: state <= DATA;
                        DATA: begin
                            shreg <= shreg >> 1;
                            bcnt  <= bcnt == B_LAST ? '0 : bcnt + 1'b1;
`ifdef IRDA_SIR_ENC_PARITY_EN
                            if (bcnt == B_LAST) state <= PARITY;
                        end
                        PARITY: state <= STOP;
`else
                            if (bcnt == B_LAST) state <= STOP;
                        end
`endif
                        STOP: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_irda_sir_frame_encoder.sv
// tb_irda_sir_frame_encoder: table of whole-frame vectors plus back-to-back, abort and reset sequences.
`timescale 1ns/1ps
module tb_irda_sir_frame_encoder;
`ifdef IRDA_SIR_ENC_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = 16 * NB;

    logic       clk = 1'b0, wb_rst_n = 1'b0, fast_mode = 1'b0, baud_en = 1'b0;
    logic       tx_valid = 1'b0, pulse_mode = 1'b0, parity_odd = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, sir_enc_o, busy, tx_ready_t, sir_t, busy_t;
    int         nvec = 0, nbad = 0;

    always #5 clk = ~clk;

    irda_sir_frame_encoder dut (
        .clk(clk), .wb_rst_n(wb_rst_n), .fast_mode(fast_mode), .baud_en(baud_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .pulse_mode(pulse_mode),
`ifdef IRDA_SIR_ENC_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .sir_enc_o(sir_enc_o), .busy(busy)
    );

    // Long short-pulse variant so a pulse outlives its bit and gets truncated.
    irda_sir_frame_encoder #(.SHORT_CLKS(12)) dut_t (
        .clk(clk), .wb_rst_n(wb_rst_n), .fast_mode(fast_mode), .baud_en(baud_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_t), .pulse_mode(pulse_mode),
`ifdef IRDA_SIR_ENC_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .sir_enc_o(sir_t), .busy(busy_t)
    );

    typedef struct {
        logic [7:0] data;
        logic       mode;
        int         div;
        logic       po;
        int         mask;
        int         pmask;
        int         width;
        int         tw;
    } vec_t;

    vec_t vecs[8];
    int   rises[$], exp_r[$];
    int   m2[2];
    int   rdy_k, gap, hits;
    logic prev;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int k, w, wt, wmin, wmax, twmax, np, bad_off, bt, m, em;
        logic pv, done;
`ifdef IRDA_SIR_ENC_PARITY_EN
        em = v.pmask;
`else
        em = v.mask;
`endif
        tx_data = v.data; pulse_mode = v.mode; parity_odd = v.po; tx_valid = 1'b1; baud_en = 1'b0;
        @(negedge clk);
        chk({tag, " ready"}, int'(tx_ready), 1);
        @(posedge clk); #1;
        tx_valid = 1'b0; tx_data = ~v.data; pulse_mode = ~v.mode; parity_odd = ~v.po;
        k = 0; w = 0; wt = 0; wmin = 999; wmax = 0; twmax = 0; np = 0; bad_off = 0; bt = 0; m = 0;
        pv = 1'b0; done = 1'b0;
        while (!done && k < FL * v.div + 50) begin
            baud_en = (k % v.div) == 0;
            @(negedge clk);
            if (sir_enc_o && !pv) begin
                np++;
                w = 0;
                m |= 1 << ((k - 1) / (16 * v.div));
                if ((k - 1) % (16 * v.div) != 8 * v.div) bad_off++;
            end
            if (sir_enc_o) w++;
            if (!sir_enc_o && pv) begin
                if (w < wmin) wmin = w;
                if (w > wmax) wmax = w;
            end
            if (sir_t) begin
                wt++;
                if (wt > twmax) twmax = wt;
            end else wt = 0;
            if (busy && baud_en) bt++;
            done = !busy;
            pv = sir_enc_o;
            @(posedge clk); #1;
            k++;
        end
        baud_en = 1'b0;
        chk({tag, " done"}, int'(done), 1);
        chk({tag, " mask"}, m, em);
        chk({tag, " pulses"}, np, $countones(em));
        chk({tag, " offset"}, bad_off, 0);
        chk({tag, " wmin"}, wmin, v.width);
        chk({tag, " wmax"}, wmax, v.width);
        chk({tag, " busy ticks"}, bt, FL);
        chk({tag, " idle sir"}, int'(sir_enc_o), 0);
        if (v.tw != 0) chk({tag, " trunc"}, twmax, v.tw);
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b0, 1, 1'b0, 'h155, 'h355, 3, 0};
        vecs[1] = '{8'h00, 1'b1, 8, 1'b0, 'h1FF, 'h3FF, 4, 0};
        vecs[2] = '{8'hFF, 1'b0, 2, 1'b0, 'h001, 'h201, 6, 0};
        vecs[3] = '{8'hA5, 1'b0, 1, 1'b0, 'h0B5, 'h2B5, 3, 0};
        vecs[4] = '{8'h3C, 1'b1, 1, 1'b0, 'h187, 'h387, 4, 7};
        vecs[5] = '{8'h80, 1'b0, 3, 1'b0, 'h0FF, 'h0FF, 9, 0};
        vecs[6] = '{8'h07, 1'b0, 1, 1'b0, 'h1F1, 'h1F1, 3, 0};
        vecs[7] = '{8'h07, 1'b1, 1, 1'b1, 'h1F1, 'h3F1, 4, 0};

        #12;
        chk("reset sir", int'(sir_enc_o), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset ready", int'(tx_ready), 0);
        @(posedge clk); #1;
        wb_rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset ready", int'(tx_ready), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back frames with tx_valid held high
`ifdef IRDA_SIR_ENC_PARITY_EN
        m2[0] = 'h2B5; m2[1] = 'h387;
`else
        m2[0] = 'h0B5; m2[1] = 'h187;
`endif
        tx_data = 8'hA5; pulse_mode = 1'b0; parity_odd = 1'b0; tx_valid = 1'b1; baud_en = 1'b0;
        @(posedge clk); #1;
        tx_data = 8'h3C;
        rdy_k = -1; gap = 0; prev = 1'b0;
        for (int k = 0; k < 2 * FL + 5; k++) begin
            baud_en = 1'b1;
            @(negedge clk);
            if (tx_ready && busy && rdy_k < 0) rdy_k = k;
            if (k < 2 * FL && !busy) gap++;
            if (sir_enc_o && !prev) rises.push_back(k);
            prev = sir_enc_o;
            @(posedge clk); #1;
            if (rdy_k == k) tx_valid = 1'b0;
        end
        tx_valid = 1'b0; baud_en = 1'b0;
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < NB; b++)
                if (m2[f][b]) exp_r.push_back(f * FL + 16 * b + 9);
        chk("b2b ready cycle", rdy_k, FL - 1);
        chk("b2b busy gap", gap, 0);
        chk("b2b end busy", int'(busy), 0);
        chk("b2b pulse count", rises.size(), exp_r.size());
        for (int i = 0; i < rises.size() && i < exp_r.size(); i++)
            chk($sformatf("b2b rise%0d", i), rises[i], exp_r[i]);

        // fast_mode abort during data bit 3 of 0x00
        tx_data = 8'h00; pulse_mode = 1'b0; tx_valid = 1'b1; baud_en = 1'b0;
        @(posedge clk); #1;
        tx_valid = 1'b0; hits = 0;
        for (int k = 0; k < 140; k++) begin
            baud_en = 1'b1;
            fast_mode = (k == 73 || k == 120);
            @(negedge clk);
            if (k == 73) begin
                chk("abort sir before", int'(sir_enc_o), 1);
                chk("abort ready", int'(tx_ready), 0);
            end
            if (k == 74) begin
                chk("abort sir", int'(sir_enc_o), 0);
                chk("abort busy", int'(busy), 0);
            end
            if (k == 120) chk("fast idle ready", int'(tx_ready), 0);
            if (k > 74 && sir_enc_o) hits++;
            @(posedge clk); #1;
        end
        fast_mode = 1'b0; baud_en = 1'b0;
        chk("abort residual", hits, 0);
        run_frame(vecs[0], "post-abort");

        // Reset asserted in the middle of a short pulse
        tx_data = 8'h00; pulse_mode = 1'b1; tx_valid = 1'b1; baud_en = 1'b0;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            baud_en = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst pre sir", int'(sir_enc_o), 1);
        #1 wb_rst_n = 1'b0;
        #1;
        chk("rst async sir", int'(sir_enc_o), 0);
        chk("rst async busy", int'(busy), 0);
        chk("rst ready", int'(tx_ready), 0);
        @(posedge clk); #1;
        wb_rst_n = 1'b1; hits = 0;
        for (int k = 0; k < 40; k++) begin
            baud_en = 1'b1;
            @(negedge clk);
            if (sir_enc_o) hits++;
            @(posedge clk); #1;
        end
        baud_en = 1'b0;
        @(negedge clk);
        chk("rst residual", hits, 0);
        chk("rst idle ready", int'(tx_ready), 1);
        chk("rst idle busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
